// File: rtl/addsub_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module  : addsub_cla_pipe
// Purpose : Add/subtract unit built on a group carry-lookahead adder, with an
//           accumulator, valid/ready handshake and one output register stage.
//           Optional macro ADDSUB_SATURATE_EN clamps signed overflow.
// Revision: 1.0 - initial release
// ============================================================================
module addsub_cla_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc
);

    localparam int GROUPS = WIDTH / 4;

    logic [WIDTH-1:0]  opx;
    logic [WIDTH-1:0]  opy;
    logic              cin;
    logic [WIDTH-1:0]  bit_g;
    logic [WIDTH-1:0]  bit_p;
    logic [WIDTH:0]    bc;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   gc;
    logic [WIDTH-1:0]  sum;
    logic              carry_out;
    logic              overflow;
    logic [WIDTH-1:0]  final_res;
    logic              accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Subtraction is X + ~b + 1; op[0] doubles as the carry-in.
    assign opx   = op[1] ? acc : a;
    assign opy   = op[0] ? ~b : b;
    assign cin   = op[0];
    assign bit_g = opx & opy;
    assign bit_p = opx ^ opy;

    generate
        for (genvar i = 0; i < GROUPS; i++) begin : g_group
            localparam int L = 4 * i;
            assign grp_p[i] = &bit_p[L+3:L];
            assign grp_g[i] = bit_g[L+3]
                            | (bit_p[L+3] & bit_g[L+2])
                            | (bit_p[L+3] & bit_p[L+2] & bit_g[L+1])
                            | (bit_p[L+3] & bit_p[L+2] & bit_p[L+1] & bit_g[L]);
            assign bc[L]   = gc[i];
            assign bc[L+1] = bit_g[L] | (bit_p[L] & gc[i]);
            assign bc[L+2] = bit_g[L+1]
                           | (bit_p[L+1] & bit_g[L])
                           | (bit_p[L+1] & bit_p[L] & gc[i]);
            assign bc[L+3] = bit_g[L+2]
                           | (bit_p[L+2] & bit_g[L+1])
                           | (bit_p[L+2] & bit_p[L+1] & bit_g[L])
                           | (bit_p[L+2] & bit_p[L+1] & bit_p[L] & gc[i]);
        end
    endgenerate

    // Two-level lookahead: each group carry is a flat sum of products of the
    // group G/P terms and cin, never a chain through the previous carry.
    always_comb begin
        gc[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            logic any_term;
            logic prod;
            any_term = 1'b0;
            for (int k = 0; k <= j; k++) begin
                prod = grp_g[k];
                for (int m = k + 1; m <= j; m++) begin
                    prod = prod & grp_p[m];
                end
                any_term = any_term | prod;
            end
            prod = cin;
            for (int m = 0; m <= j; m++) begin
                prod = prod & grp_p[m];
            end
            gc[j+1] = any_term | prod;
        end
    end

    assign bc[WIDTH]  = gc[GROUPS];
    assign sum        = bit_p ^ bc[WIDTH-1:0];
    assign carry_out  = bc[WIDTH];
    assign overflow   = bc[WIDTH] ^ bc[WIDTH-1];

`ifdef ADDSUB_SATURATE_EN
    // Overflow needs equal effective operand signs, so opx's sign picks the rail.
    assign final_res = !overflow ? sum :
                       opx[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign final_res = sum;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            acc       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                result    <= final_res;
                flags     <= {carry_out, overflow, (final_res == '0), final_res[WIDTH-1]};
                if (op[1]) begin
                    acc <= final_res;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_cla_pipe
// Purpose : Self-checking bench; directed cases plus random traffic vs model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_cla_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic [W-1:0] acc;

    addsub_cla_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    bit           m_valid;
    logic [W-1:0] m_res;
    logic [3:0]   m_flags;
    logic [W-1:0] m_acc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {carry, overflow, zero, negative, result} from integer arithmetic.
    function automatic logic [W+3:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y, input bit sub);
        longint ux, uy, sx, sy, eu, es;
        longint maxs, mins;
        logic [W-1:0] r;
        bit c, v;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        maxs = (64'sd1 <<< (W - 1)) - 1;
        mins = -(64'sd1 <<< (W - 1));
        if (sub) begin
            eu = ux - uy;
            es = sx - sy;
            c  = (ux >= uy);
        end else begin
            eu = ux + uy;
            es = sx + sy;
            c  = (eu >= (64'sd1 <<< W));
        end
        r = eu[W-1:0];
        v = (es > maxs) || (es < mins);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = (es > 0) ? maxs[W-1:0] : mins[W-1:0];
`endif
        return {c, v, (r == '0), r[W-1], r};
    endfunction

    // One clock: drive at posedge+1, check ready at posedge+3, outputs at posedge+1.
    task automatic cycle(input bit v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [1:0] iop, input bit ordy);
        bit exp_ready, take;
        logic [W+3:0] calc;
        in_valid  = v;
        a         = ia;
        b         = ib;
        op        = iop;
        out_ready = ordy;
        #2;
        exp_ready = !m_valid || ordy;
        check_eq("in_ready", in_ready, exp_ready);
        take = v && exp_ready;
        @(posedge clk);
        #1;
        if (take) begin
            calc    = ref_calc(iop[1] ? m_acc : ia, ib, iop[0]);
            m_valid = 1'b1;
            m_res   = calc[W-1:0];
            m_flags = calc[W+3:W];
            if (iop[1]) m_acc = m_res;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check_eq("out_valid", out_valid, m_valid);
        check_eq("acc", acc, m_acc);
        if (m_valid) begin
            check_eq("result", result, m_res);
            check_eq("flags", flags, m_flags);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_res   = '0;
        m_flags = '0;
        m_acc   = '0;
    endtask

    logic [W-1:0] held_res;
    logic [3:0]   held_flags;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = '0;
        b         = 16'h0001;
        op        = 2'b00;
        model_reset();
        #12;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_result", result, '0);
        check_eq("rst_flags", flags, 4'h0);
        check_eq("rst_acc", acc, '0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;

        // Accumulate sequence; first accept is on the first edge after release.
        cycle(1'b1, 16'h0000, 16'h0010, 2'b10, 1'b1);
        check_eq("acc_seq_r0", result, 16'h0010);
        cycle(1'b1, 16'h0000, 16'h0020, 2'b10, 1'b1);
        check_eq("acc_seq_r1", result, 16'h0030);
        cycle(1'b1, 16'h0000, 16'hFFFF, 2'b10, 1'b1);
        check_eq("acc_seq_r2", result, 16'h002F);
        check_eq("acc_seq_acc", acc, 16'h002F);
        check_eq("acc_seq_carry", flags[3], 1'b1);

        cycle(1'b1, 16'h7FFF, 16'h0001, 2'b00, 1'b1);
`ifdef ADDSUB_SATURATE_EN
        check_eq("ovf_result", result, 16'h7FFF);
        check_eq("ovf_flags", flags, 4'b0100);
`else
        check_eq("ovf_result", result, 16'h8000);
        check_eq("ovf_flags", flags, 4'b0101);
`endif
        check_eq("ovf_acc_kept", acc, 16'h002F);

        cycle(1'b1, 16'h0005, 16'h0005, 2'b01, 1'b1);
        check_eq("sub_eq_result", result, 16'h0000);
        check_eq("sub_eq_flags", flags, 4'b1010);
        cycle(1'b1, 16'h0003, 16'h0005, 2'b01, 1'b1);
        check_eq("sub_borrow_result", result, 16'hFFFE);
        check_eq("sub_borrow_flags", flags, 4'b0001);

        // Backpressure: result must hold while out_ready is low.
        cycle(1'b1, 16'h1111, 16'h2222, 2'b00, 1'b0);
        held_res   = result;
        held_flags = flags;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pick(), pick(), 2'($urandom), 1'b0);
            check_eq("hold_result", result, held_res);
            check_eq("hold_flags", flags, held_flags);
        end
        cycle(1'b1, 16'h0100, 16'h0023, 2'b00, 1'b1);
        check_eq("reload_result", result, 16'h0123);
        check_eq("reload_valid", out_valid, 1'b1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), pick(), pick(), 2'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream with a pending result and a known accumulator.
        cycle(1'b1, 16'h0000, 16'h1234 - m_acc, 2'b10, 1'b1);
        cycle(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0);
        check_eq("pre_rst_acc", acc, 16'h1234);
        check_eq("pre_rst_valid", out_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 1'b0);
        check_eq("async_rst_result", result, '0);
        check_eq("async_rst_flags", flags, 4'h0);
        check_eq("async_rst_acc", acc, '0);
        check_eq("async_rst_ready", in_ready, 1'b1);
        model_reset();
        in_valid = 1'b1;
        op       = 2'b10;
        b        = 16'h0055;
        @(posedge clk);
        #1;
        check_eq("in_rst_no_accept", out_valid, 1'b0);
        check_eq("in_rst_acc", acc, '0);
        reset_n = 1'b1;
        cycle(1'b1, 16'h0000, 16'h0042, 2'b10, 1'b1);
        check_eq("post_rst_acc", acc, 16'h0042);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, pick(), pick(), 2'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_cla_pipe.md
ADDSUB_CLA_PIPE -- requirements
Module: addsub_cla_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4, range 4..64.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operands and op presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH each, operands in two's complement or unsigned.
REQ-007 SHALL have port op, input, 2, operation select: 00 a+b, 01 a-b, 10 acc+b, 11 acc-b.
REQ-008 SHALL have port out_valid, output, 1, result registers hold an unconsumed result.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-010 SHALL have port result, output, WIDTH, sum/difference.
REQ-011 SHALL have port flags, output, 4, {carry, overflow, zero, negative}.
REQ-012 SHALL have port acc, output, WIDTH, current accumulator value.

Function
REQ-013 SHALL compute with a carry-lookahead adder of WIDTH/4 groups; each group SHALL produce group propagate/generate, and inter-group carries SHALL come from lookahead logic, not ripple.
REQ-014 SHALL implement subtraction as X + ~b + 1 (carry-in = op[0]); carry SHALL be the raw MSB carry-out, so carry=1 means no borrow.
REQ-015 SHALL set overflow = carry-out of bit WIDTH-1 XOR carry-in to bit WIDTH-1; zero = (result == 0); negative = result[WIDTH-1].
REQ-016 SHALL accept a transaction on a cycle where in_valid and in_ready are both 1 (handshake).
REQ-017 SHALL drive in_ready = !out_valid || out_ready (single output register, combinational ready).
REQ-018 SHALL register result and flags on acceptance and assert out_valid on the next cycle (latency 1).
REQ-019 SHALL hold result, flags and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL deassert out_valid after a cycle with out_valid=1 and out_ready=1 and no new acceptance; with simultaneous consume and accept, out_valid SHALL stay 1 and new data SHALL load (full throughput, one result per cycle).
REQ-021 For op 1x the first operand SHALL be the acc value at the accepting edge; a is ignored.
REQ-022 SHALL update acc with the (possibly saturated) result on acceptance of op 1x only; op 0x SHALL leave acc unchanged.
REQ-023 Back-to-back op 1x acceptances SHALL each see the acc written by the previous acceptance, with no stall.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH unless the feature of REQ-028 is enabled.

Reset
REQ-025 On reset_n=0, out_valid, result, flags and acc SHALL clear to 0 asynchronously; in_ready SHALL read 1 while in reset.
REQ-026 A result pending when reset asserts SHALL be discarded; no transaction SHALL be accepted while reset_n=0.
REQ-027 The first acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-028 With macro ADDSUB_SATURATE_EN defined, any signed overflow SHALL clamp the result to max positive (0111...1) if both effective operands are non-negative, else to min negative (100...0); the overflow flag SHALL still report 1, and zero/negative SHALL reflect the clamped value.
REQ-029 Without ADDSUB_SATURATE_EN, no clamping logic SHALL be present and results SHALL wrap.

Verification (WIDTH=16)
REQ-030 a=0x7FFF, b=0x0001, op=00 -> next cycle result=0x8000, flags carry=0 ovf=1 zero=0 neg=1; with ADDSUB_SATURATE_EN result=0x7FFF, neg=0.
REQ-031 a=0x0005, b=0x0005, op=01 -> result=0x0000, carry=1, ovf=0, zero=1, neg=0; a=0x0003, b=0x0005, op=01 -> result=0xFFFE, carry=0, neg=1.
REQ-032 After reset, three consecutive op=10 with b=0x0010, 0x0020, 0xFFFF and out_ready=1 -> results 0x0010, 0x0030, 0x002F; acc=0x002F; final carry=1.
REQ-033 out_ready held 0 with result pending, in_valid=1 -> in_ready=0, result/flags unchanged for 5 cycles; raise out_ready -> pending result consumed and new operands loaded same edge.
REQ-034 Assert reset_n=0 mid-stream with out_valid=1 and acc=0x1234 -> out_valid, result, flags, acc read 0 immediately, before the next clock edge.
